serial_adder_seq: RTL

Bit-serial N-bit adder sequencer that sits directly upstream of the 1-bit full-adder slice. It accepts two parallel operands plus carry-in over a valid/ready handshake. Each cycle it presents one bit pair and the registered carry to the slice, LSB first, and collects the slice's sum bit. It returns the parallel sum and carry-out over a second valid/ready handshake.

---
 rtl/serial_add_pkg.sv | 14 +
 rtl/fa_slice.sv | 15 +
 rtl/serial_adder_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared definitions for the bit-serial adder sequencer.
//   state_t   : sequencer FSM encoding (IDLE, SHIFT, DONE)
//   DEF_WIDTH : default operand/sum width
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/fa_slice.sv
// fa_slice: combinational 1-bit full adder.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module fa_slice (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial WIDTH-bit adder sequencer driving one fa_slice.
// Accepts {a,b,cin} on an in_valid/in_ready handshake, feeds one bit pair per
// cycle (LSB first) plus the registered carry to the slice, and returns
// {cout,sum} on an out_valid/out_ready handshake.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake (a, b, cin)
//   out_valid/out_ready  : result handshake (sum, cout)
//   busy                 : high in SHIFT or DONE
//   ovf                  : signed overflow, only when SERIAL_ADD_OVF_EN is defined
module serial_adder_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             s_bit, c_bit;

  assign last = (cnt == CW'(WIDTH - 1));

  fa_slice u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr  <= a;
          b_sr  <= b;
          carry <= cin;
          cnt   <= '0;
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
          carry  <= c_bit;
          // Hold at WIDTH-1 on the final edge so the counter never wraps.
          if (!last) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_sr;
  assign cout = carry;

`ifdef SERIAL_ADD_OVF_EN
  // Carry into the MSB: the carry register just before the final SHIFT edge.
  logic c_msb;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      c_msb <= 1'b0;
    else if (state == SHIFT && last) c_msb <= carry;
  end
  assign ovf = c_msb ^ carry;
`endif

endmodule
